// File: rtl/pulse_width_meter.sv
// Measures data_in high time from edge-detector pulses; 1-deep valid/ready result.
// Optional PULSE_LOW_MEAS_EN also measures low time and adds width_is_low.
module pulse_width_meter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_posedge,
    input  logic             data_negedge,
    input  logic             width_ready,
    input  logic             clr_err,
    output logic [CNT_W-1:0] width_data,
    output logic             width_sat,
    output logic             width_valid,
`ifdef PULSE_LOW_MEAS_EN
    output logic             width_is_low,
`endif
    output logic             overrun,
    output logic             proto_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef PULSE_LOW_MEAS_EN
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
`else
    typedef enum logic [1:0] {IDLE, HIGH} state_t;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             cnt_sat, sat_nxt, sat_inc;
    logic             res_vld, res_low, perr;
    logic             xfer, load;

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    assign sat_inc = cnt_sat | (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            cnt_sat <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            cnt_sat <= sat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sat_nxt   = cnt_sat;
        res_vld   = 1'b0;
        res_low   = 1'b0;
        perr      = 1'b0;
        // Simultaneous edges are ambiguous: flag and freeze everything.
        if (data_posedge && data_negedge) begin
            perr = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (data_posedge) begin
                        state_nxt = HIGH;
                        cnt_nxt   = CNT_ONE;
                        sat_nxt   = 1'b0;
                    end
`ifdef PULSE_LOW_MEAS_EN
                    else if (data_negedge) begin
                        state_nxt = LOW;
                        cnt_nxt   = CNT_ONE;
                        sat_nxt   = 1'b0;
                    end
`endif
                end
                HIGH: begin
                    if (data_negedge) begin
                        res_vld = 1'b1;
`ifdef PULSE_LOW_MEAS_EN
                        state_nxt = LOW;
                        cnt_nxt   = CNT_ONE;
                        sat_nxt   = 1'b0;
`else
                        state_nxt = IDLE;
`endif
                    end else if (data_posedge) begin
                        perr    = 1'b1;
                        cnt_nxt = CNT_ONE;
                        sat_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt_inc;
                        sat_nxt = sat_inc;
                    end
                end
`ifdef PULSE_LOW_MEAS_EN
                LOW: begin
                    if (data_posedge) begin
                        res_vld   = 1'b1;
                        res_low   = 1'b1;
                        state_nxt = HIGH;
                        cnt_nxt   = CNT_ONE;
                        sat_nxt   = 1'b0;
                    end else if (data_negedge) begin
                        perr    = 1'b1;
                        cnt_nxt = CNT_ONE;
                        sat_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt_inc;
                        sat_nxt = sat_inc;
                    end
                end
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign xfer = width_valid && width_ready;
    assign load = res_vld && (!width_valid || xfer);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            width_data   <= '0;
            width_sat    <= 1'b0;
            width_valid  <= 1'b0;
`ifdef PULSE_LOW_MEAS_EN
            width_is_low <= 1'b0;
`endif
            overrun      <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            if (load) begin
                width_data   <= cnt;
                width_sat    <= cnt_sat;
                width_valid  <= 1'b1;
`ifdef PULSE_LOW_MEAS_EN
                width_is_low <= res_low;
`endif
            end else if (xfer) begin
                width_valid <= 1'b0;
            end
            overrun   <= (res_vld && !load) || (overrun && !clr_err);
            proto_err <= perr || (proto_err && !clr_err);
        end
    end

`ifndef PULSE_LOW_MEAS_EN
    logic unused;
    assign unused = res_low;
`endif

endmodule

// File: doc/pulse_width_meter.md
Name: pulse_width_meter

Overview:
- Downstream consumer of the edge detector stage. Takes its single-cycle data_posedge and data_negedge pulses and measures the high time of data_in in clk cycles.
- Each completed measurement is presented on a valid/ready output with a 1-deep holding register.
- Saturation and overrun are reported for the control/status logic.

Parameters:
- CNT_W, 16, width of the width counter and of width_data; the maximum count is 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset. Asserts immediately; deasserts synchronously to clk.
- data_posedge  input  1  1-cycle pulse from the edge detector on a 0->1 transition of data_in.
- data_negedge  input  1  1-cycle pulse from the edge detector on a 1->0 transition of data_in.
- width_ready  input  1  consumer accepts width_data when high with width_valid.
- clr_err  input  1  synchronous clear of the sticky error flags.
- width_data  output  CNT_W  measured high time, in cycles.
- width_sat  output  1  the measurement in width_data saturated.
- width_valid  output  1  width_data/width_sat hold an unconsumed measurement.
- overrun  output  1  sticky: a measurement was dropped because the holding register was full.
- proto_err  output  1  sticky: an illegal edge sequence was seen.

Behaviour:
- Reset (rst=0): state=IDLE, cnt=0, width_data=0, width_sat=0, width_valid=0, overrun=0, proto_err=0. Reset mid-measurement discards the count in progress and any held result.

State IDLE:
- data_posedge=1 and data_negedge=0: cnt<=1, cnt_sat<=0, go to HIGH.
- data_negedge alone: ignored; no flag is set.

State HIGH:
- Neither pulse: cnt<=cnt+1, saturating at 2^CNT_W-1. cnt_sat<=1 when an increment is attempted at the maximum.
- data_negedge=1 and data_posedge=0: result={cnt, cnt_sat}, go to IDLE.
- data_posedge=1 and data_negedge=0 (missed negedge): proto_err<=1, cnt<=1, cnt_sat<=0, stay in HIGH (restart).

Both pulses in the same cycle, any state:
- proto_err<=1.
- State, cnt and cnt_sat are unchanged; no result is produced.

Width rule:
- If data_posedge is seen in cycle k and data_negedge in cycle k+N, the result is N.
- Minimum is N=1. Values above 2^CNT_W-1 report 2^CNT_W-1 with width_sat=1.

Output latency:
- The result is registered: width_valid rises in cycle k+N+1.

Handshake:
- A transfer occurs when width_valid and width_ready are both 1 at a rising edge.
- width_data and width_sat stay stable while width_valid=1 and width_ready=0.
- Result produced while width_valid=0, or in the same cycle as a transfer: loaded; width_valid=1 next cycle (back-to-back, no bubble).
- Result produced while width_valid=1 and no transfer: the new result is dropped, overrun<=1, held data unchanged.
- Transfer with no new result: width_valid<=0.

Sticky flags:
- Cleared by clr_err=1.
- If a set event and clr_err occur in the same cycle, set wins (flag=1).

Counter width:
- cnt is CNT_W bits; the saturation compare is against all-ones. No wrap-around ever occurs.

Optional Feature:
Macro PULSE_LOW_MEAS_EN.
- Defined:
  - Low time is also measured: data_negedge starts counting in a LOW state with the same rules, and data_posedge in LOW ends the measurement (result N = cycles from negedge to posedge).
  - The posedge that ends a LOW measurement also starts the next HIGH measurement in the same cycle.
  - Adds output port width_is_low (1 bit, reset 0), held and handshaked with width_data: 1 = low-time result, 0 = high-time result.
  - In LOW, a negedge without a posedge sets proto_err and restarts the low count.
- Undefined: no LOW state, no width_is_low port; behaviour is exactly as described above.

Test Plan:
- Reset, then data_in high for 5 cycles, width_ready=1 -> width_valid for 1 cycle one cycle after data_negedge, width_data=5, width_sat=0.
- Single-cycle high pulse -> width_data=1. Two high pulses of 3 and 7 cycles with width_ready=1 -> two transfers, values 3 then 7, overrun=0.
- CNT_W=4, data_in high for 20 cycles -> width_data=15, width_sat=1; next pulse of 4 cycles -> width_data=4, width_sat=0.
- width_ready=0, pulses of 3 then 6 cycles -> width_data stays 3 with width_valid=1 and overrun=1; raise width_ready -> 3 transfers, width_valid drops; clr_err -> overrun=0.
- Force data_posedge twice without data_negedge (2 cycles apart), then data_negedge 4 cycles later -> proto_err=1, width_data=4. Force both pulses together in IDLE -> proto_err=1, no result.
- Assert rst low during a 10-cycle pulse after 4 cycles -> all outputs 0 immediately; no result when data_negedge arrives after reset release. With PULSE_LOW_MEAS_EN, high 3 / low 5 -> results 3 (width_is_low=0) then 5 (width_is_low=1).
